fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
// Sequencer for the prog_counter fetch datapath. Drives start, start_addr, branch, taken and target.
// Takes a launch request, runs the program, and honours stall, branch and halt requests from the core.
// Stalls are a branch-taken-to-self, because prog_counter has no enable.
// Ends each run with a cycle count and a done or timeout status.
// PARAMETERS
// width      9      PC / address width, matches prog_counter
// CNT_W      16     cycle counter width
// MAX_CYCLES 4000   RUN+STALL cycles before forced timeout; 0 disables the timeout
// PORTS
// clk          in   1        clock; all state updates on posedge
// reset        in   1        synchronous, active-high
// go           in   1        launch request; sampled only in IDLE or DONE
// go_addr      in   width    program entry address, latched when go is accepted
// stall        in   1        hold the PC at its current value this cycle
// br_req       in   1        execute stage has a branch this cycle
// br_taken     in   1        branch condition result; qualified by br_req
// br_target    in   width    branch destination
// halt_req     in   1        program end; finish the run
// pc_in        in   width    current PC (prog_counter pc_out)
// pc_start     out  1        to prog_counter start
// pc_start_addr out width    to prog_counter start_addr
// pc_branch    out  1        to prog_counter branch
// pc_taken     out  1        to prog_counter taken
// pc_target    out  width    to prog_counter target
// fetch_valid  out  1        instruction at pc_in is valid to execute this cycle
// busy         out  1        state is LOAD, RUN or STALL
// done         out  1        run finished (halt or timeout); held until next launch
// timeout      out  1        run ended by MAX_CYCLES; held until next launch
// cycle_count  out  CNT_W    RUN+STALL cycles of the current/last run; saturates at all-ones
// BEHAVIOUR
// - States: IDLE, LOAD, RUN, STALL, DONE.
// - Reset: state=IDLE, latched addr=0, cycle_count=0, done=0, timeout=0.
// - Reset takes effect at the next edge from any state; an in-flight run is abandoned.
// - All pc_* outputs, fetch_valid and busy are combinational from state and inputs.
// - Every output is 0 except pc_start=1 with pc_start_addr=latched addr in IDLE and LOAD.
// - IDLE: go=1 -> latch go_addr, clear cycle_count/done/timeout, go to LOAD.
// - LOAD (1 cycle): pc_start=1, pc_start_addr=latched addr, go to RUN. The PC equals the entry address in the first RUN cycle.
// - RUN: fetch_valid=1.
//   - Priority is halt_req > stall > br_req.
//   - halt_req=1 -> DONE; any branch in the same cycle is dropped.
//   - stall=1 -> STALL; this cycle already drives the hold: pc_branch=1, pc_taken=1, pc_target=pc_in.
//   - Otherwise pc_branch=br_req, pc_taken=br_req&br_taken, pc_target=br_target.
// - STALL: fetch_valid=0. Hold via pc_branch=1, pc_taken=1, pc_target=pc_in.
//   - stall=0 -> RUN; halt_req in STALL -> DONE.
//   - br_req is ignored while stalled; the requester must hold the branch until stall is 0.
// - DONE: done=1, PC held by branch-to-self, fetch_valid=0, busy=0.
//   - go=1 -> latch new go_addr, clear status, go to LOAD.
//   - go in LOAD, RUN or STALL is ignored.
// - cycle_count +1 every RUN or STALL cycle; saturates, never wraps. Holds its value in DONE and IDLE.
// - Timeout: MAX_CYCLES!=0 and cycle_count reaches MAX_CYCLES-1 in RUN/STALL.
//   - Go to DONE on that edge, with timeout=1 and done=1.
//   - A halt_req in the same cycle gives done=1, timeout=0 (halt wins).
// - pc_in wrap (2^width-1 -> 0) is the PC's behaviour; fetch_ctrl does not check it.
// TESTING
// - reset, go=1 go_addr=9'd16 -> LOAD 1 cycle with pc_start=1 addr=16; RUN with pc_in=16 and fetch_valid=1; busy=1.
// - RUN, br_req=1 br_taken=1 br_target=9'd40 -> pc_branch=pc_taken=1, target 40. With br_taken=0 -> pc_taken=0 and the PC increments.
// - RUN at pc=20, stall=1 for 3 cycles -> pc_target=20 each cycle, fetch_valid=0 in STALL, pc stays 20. Resumes 21 after release; cycle_count counts stalls.
// - halt_req=1 with br_req=1 in the same cycle -> branch dropped, done=1 next cycle, timeout=0, cycle_count frozen. Then go=1 go_addr=0 -> relaunch at 0 with status cleared.
// - MAX_CYCLES=8, no halt -> done=1 timeout=1 after 8 RUN cycles, cycle_count=8.
// - reset=1 mid-RUN -> IDLE next cycle, pc_start=1 addr=0, cycle_count=0. go in RUN ignored: no re-latch, no LOAD.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// ============================================================================
// Module : fetch_ctrl_if
// Brief  : Signal bundle between the fetch sequencer, the core handshake
//          (launch, stall, branch, halt) and the prog_counter datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_ctrl_if #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 16
);

  // Core side requests and PC feedback
  logic             go;
  logic [WIDTH-1:0] go_addr;
  logic             stall;
  logic             br_req;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             halt_req;
  logic [WIDTH-1:0] pc_in;

  // prog_counter controls
  logic             pc_start;
  logic [WIDTH-1:0] pc_start_addr;
  logic             pc_branch;
  logic             pc_taken;
  logic [WIDTH-1:0] pc_target;

  // Run status
  logic             fetch_valid;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;

  // Sequencer view
  modport master (
    input  go, go_addr, stall, br_req, br_taken, br_target, halt_req, pc_in,
    output pc_start, pc_start_addr, pc_branch, pc_taken, pc_target,
    output fetch_valid, busy, done, timeout, cycle_count
  );

  // Core / datapath view
  modport slave (
    output go, go_addr, stall, br_req, br_taken, br_target, halt_req, pc_in,
    input  pc_start, pc_start_addr, pc_branch, pc_taken, pc_target,
    input  fetch_valid, busy, done, timeout, cycle_count
  );

endinterface

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module : fetch_ctrl
// Brief  : Sequencer for the prog_counter fetch datapath. Launches a run at a
//          latched entry address, forwards branches, holds the PC during
//          stalls with a taken branch to the current PC, and ends the run on
//          halt or on a cycle budget, reporting the cycle count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_ctrl #(
  parameter int WIDTH      = 9,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 4000
) (
  input  wire logic     clk,
  input  wire logic     reset,
  fetch_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_STALL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Saturation value of the cycle counter
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  // Counter value seen during the last permitted RUN/STALL cycle
  localparam logic [63:0]      LIMIT   = 64'(MAX_CYCLES) - 64'd1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             timeout_q;

  logic             active;      // a RUN or STALL cycle, counted toward the budget
  logic             limit_hit;   // this cycle exhausts the budget
  logic             accept_go;   // launch accepted this cycle
  logic             end_halt;    // run ends by halt this cycle
  logic             end_limit;   // run ends by budget this cycle

  assign active    = (state == S_RUN) || (state == S_STALL);
  // A zero budget disables the timeout altogether
  assign limit_hit = (MAX_CYCLES != 0) && (64'(cnt_q) == LIMIT);

  // Next-state decision; halt outranks the budget, which outranks stall
  always_comb begin
    state_nxt = state;
    accept_go = 1'b0;
    end_halt  = 1'b0;
    end_limit = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.go) begin
          accept_go = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        state_nxt = S_RUN;
      end
      S_RUN, S_STALL: begin
        if (bus.halt_req) begin
          end_halt  = 1'b1;
          state_nxt = S_DONE;
        end else if (limit_hit) begin
          end_limit = 1'b1;
          state_nxt = S_DONE;
        end else if (bus.stall) begin
          state_nxt = S_STALL;
        end else begin
          state_nxt = S_RUN;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath controls; prog_counter has no enable, so every hold is a taken
  // branch back to the current PC
  always_comb begin
    bus.pc_start      = 1'b0;
    bus.pc_start_addr = '0;
    bus.pc_branch     = 1'b0;
    bus.pc_taken      = 1'b0;
    bus.pc_target     = '0;
    bus.fetch_valid   = 1'b0;
    bus.busy          = 1'b0;
    case (state)
      S_IDLE: begin
        bus.pc_start      = 1'b1;
        bus.pc_start_addr = addr_q;
      end
      S_LOAD: begin
        bus.pc_start      = 1'b1;
        bus.pc_start_addr = addr_q;
        bus.busy          = 1'b1;
      end
      S_RUN: begin
        bus.fetch_valid = 1'b1;
        bus.busy        = 1'b1;
        if (bus.halt_req) begin
          // Branch in the halting cycle is dropped; the PC simply advances
          bus.pc_branch = 1'b0;
        end else if (bus.stall) begin
          // Entering STALL: hold already starts on this cycle
          bus.pc_branch = 1'b1;
          bus.pc_taken  = 1'b1;
          bus.pc_target = bus.pc_in;
        end else begin
          bus.pc_branch = bus.br_req;
          bus.pc_taken  = bus.br_req & bus.br_taken;
          bus.pc_target = bus.br_target;
        end
      end
      S_STALL: begin
        // br_req ignored here; the core re-presents it after the stall
        bus.busy      = 1'b1;
        bus.pc_branch = 1'b1;
        bus.pc_taken  = 1'b1;
        bus.pc_target = bus.pc_in;
      end
      S_DONE: begin
        bus.pc_branch = 1'b1;
        bus.pc_taken  = 1'b1;
        bus.pc_target = bus.pc_in;
      end
      default: begin
        bus.pc_branch = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Entry address, saturating cycle counter and end-of-run status
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (accept_go) begin
        addr_q    <= bus.go_addr;
        cnt_q     <= '0;
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
      end
      if (active && (cnt_q != CNT_SAT)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (end_halt) begin
        done_q    <= 1'b1;
        timeout_q <= 1'b0;
      end
      if (end_limit) begin
        done_q    <= 1'b1;
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module : tb_fetch_ctrl
// Brief  : Self-checking bench for fetch_ctrl: directed scenarios plus a
//          randomized run compared against a run-level reference model. A
//          second instance with a budget of 8 cycles covers the timeout.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

  localparam int W     = 9;
  localparam int CW    = 16;
  localparam int MAXC  = 4000;
  localparam int MAXC8 = 8;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_RUN   = 2;
  localparam int M_STALL = 3;
  localparam int M_DONE  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  fetch_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus8 ();

  fetch_ctrl #(.WIDTH(W), .CNT_W(CW), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  fetch_ctrl #(.WIDTH(W), .CNT_W(CW), .MAX_CYCLES(MAXC8)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8)
  );

  // The short-budget instance sees the same core requests
  assign bus8.go        = bus.go;
  assign bus8.go_addr   = bus.go_addr;
  assign bus8.stall     = bus.stall;
  assign bus8.br_req    = bus.br_req;
  assign bus8.br_taken  = bus.br_taken;
  assign bus8.br_target = bus.br_target;
  assign bus8.halt_req  = bus.halt_req;

  // Stand-ins for prog_counter: start > taken branch > increment
  logic [W-1:0] pc  = '0;
  logic [W-1:0] pc8 = '0;
  always @(posedge clk) begin
    if (bus.pc_start)                      pc <= bus.pc_start_addr;
    else if (bus.pc_branch && bus.pc_taken) pc <= bus.pc_target;
    else                                   pc <= pc + 1'b1;
  end
  always @(posedge clk) begin
    if (bus8.pc_start)                       pc8 <= bus8.pc_start_addr;
    else if (bus8.pc_branch && bus8.pc_taken) pc8 <= bus8.pc_target;
    else                                     pc8 <= pc8 + 1'b1;
  end
  assign bus.pc_in  = pc;
  assign bus8.pc_in = pc8;

  // Run-level reference model of the main instance
  int           m_mode = M_IDLE;
  logic [W-1:0] m_addr = '0;
  logic [CW-1:0] m_cnt = '0;
  logic         m_done = 1'b0;
  logic         m_tmo  = 1'b0;

  task automatic model_update();
    bit last;
    if (reset) begin
      m_mode = M_IDLE; m_addr = '0; m_cnt = '0; m_done = 1'b0; m_tmo = 1'b0;
    end else if (m_mode == M_IDLE || m_mode == M_DONE) begin
      if (bus.go) begin
        m_mode = M_LOAD; m_addr = bus.go_addr; m_cnt = '0;
        m_done = 1'b0; m_tmo = 1'b0;
      end
    end else if (m_mode == M_LOAD) begin
      m_mode = M_RUN;
    end else begin
      // This cycle is run cycle number m_cnt+1; the budget allows MAXC of them
      last = (MAXC != 0) && (int'(m_cnt) + 1 == MAXC);
      if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      if (bus.halt_req) begin
        m_mode = M_DONE; m_done = 1'b1; m_tmo = 1'b0;
      end else if (last) begin
        m_mode = M_DONE; m_done = 1'b1; m_tmo = 1'b1;
      end else begin
        m_mode = bus.stall ? M_STALL : M_RUN;
      end
    end
  endtask

  // Expected {pc_start, pc_start_addr, pc_branch, pc_taken, pc_target, fetch_valid, busy}
  function automatic logic [2*W+4:0] predict_comb();
    logic         st, br, tk, fv, bz;
    logic [W-1:0] sa, tg;
    st = 1'b0; br = 1'b0; tk = 1'b0; fv = 1'b0; bz = 1'b0; sa = '0; tg = '0;
    if (m_mode == M_IDLE || m_mode == M_LOAD) begin
      st = 1'b1; sa = m_addr; bz = (m_mode == M_LOAD);
    end else if (m_mode == M_RUN) begin
      fv = 1'b1; bz = 1'b1;
      if (!bus.halt_req && bus.stall) begin
        br = 1'b1; tk = 1'b1; tg = bus.pc_in;
      end else if (!bus.halt_req) begin
        br = bus.br_req; tk = bus.br_req & bus.br_taken; tg = bus.br_target;
      end
    end else begin
      br = 1'b1; tk = 1'b1; tg = bus.pc_in; bz = (m_mode == M_STALL);
    end
    return {st, sa, br, tk, tg, fv, bz};
  endfunction

  function automatic logic [2*W+4:0] dut_comb();
    return {bus.pc_start, bus.pc_start_addr, bus.pc_branch, bus.pc_taken,
            bus.pc_target, bus.fetch_valid, bus.busy};
  endfunction

  // Advance one clock edge, keeping the model in step
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    bus.go = 1'b0; bus.go_addr = '0; bus.stall = 1'b0; bus.br_req = 1'b0;
    bus.br_taken = 1'b0; bus.br_target = '0; bus.halt_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.pc_start, bus.pc_start_addr, bus.busy, bus.fetch_valid, bus.done, bus.timeout, bus.cycle_count}
        !== {1'b1, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_state got start=%b addr=%0d busy=%b fv=%b done=%b to=%b cnt=%0d exp start=1 addr=0 rest 0",
               bus.pc_start, bus.pc_start_addr, bus.busy, bus.fetch_valid, bus.done, bus.timeout, bus.cycle_count);
    end
    tick();
  endtask

  task automatic test_launch();
    bus.go = 1'b1; bus.go_addr = 9'd16;
    tick();
    bus.go = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.pc_start, bus.pc_start_addr, bus.busy, bus.fetch_valid} !== {1'b1, 9'd16, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL launch_load got start=%b addr=%0d busy=%b fv=%b exp 1 16 1 0",
               bus.pc_start, bus.pc_start_addr, bus.busy, bus.fetch_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.pc_in, bus.fetch_valid, bus.busy, bus.pc_start} !== {9'd16, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL launch_run got pc=%0d fv=%b busy=%b start=%b exp 16 1 1 0",
               bus.pc_in, bus.fetch_valid, bus.busy, bus.pc_start);
    end
    tick();
  endtask

  task automatic test_branch();
    bus.br_req = 1'b1; bus.br_taken = 1'b1; bus.br_target = 9'd40;
    @(negedge clk);
    checks++;
    if ({bus.pc_branch, bus.pc_taken, bus.pc_target} !== {1'b1, 1'b1, 9'd40}) begin
      errors++;
      $display("FAIL branch_taken got br=%b tk=%b tgt=%0d exp 1 1 40",
               bus.pc_branch, bus.pc_taken, bus.pc_target);
    end
    tick();
    bus.br_taken = 1'b0; bus.br_target = 9'd99;
    @(negedge clk);
    checks++;
    if ({bus.pc_in, bus.pc_branch, bus.pc_taken} !== {9'd40, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL branch_not_taken got pc=%0d br=%b tk=%b exp 40 1 0",
               bus.pc_in, bus.pc_branch, bus.pc_taken);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (bus.pc_in !== 9'd41) begin
      errors++;
      $display("FAIL branch_increment got pc=%0d exp 41", bus.pc_in);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [CW-1:0] c0;
    bus.br_req = 1'b1; bus.br_taken = 1'b1; bus.br_target = 9'd20;
    tick();
    clear_inputs();
    bus.stall = 1'b1;
    c0 = m_cnt;
    @(negedge clk);
    checks++;
    if ({bus.pc_in, bus.pc_branch, bus.pc_taken, bus.pc_target, bus.fetch_valid} !== {9'd20, 1'b1, 1'b1, 9'd20, 1'b1}) begin
      errors++;
      $display("FAIL stall_enter got pc=%0d br=%b tk=%b tgt=%0d fv=%b exp 20 1 1 20 1",
               bus.pc_in, bus.pc_branch, bus.pc_taken, bus.pc_target, bus.fetch_valid);
    end
    tick();
    // A branch offered during the stall must not leak through
    bus.br_req = 1'b1; bus.br_taken = 1'b1; bus.br_target = 9'd300;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.pc_in, bus.pc_target, bus.pc_taken, bus.fetch_valid, bus.busy} !== {9'd20, 9'd20, 1'b1, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got pc=%0d tgt=%0d tk=%b fv=%b busy=%b exp 20 20 1 0 1",
                 i, bus.pc_in, bus.pc_target, bus.pc_taken, bus.fetch_valid, bus.busy);
      end
      tick();
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({bus.pc_in, bus.fetch_valid, bus.pc_target} !== {9'd20, 1'b0, 9'd20}) begin
      errors++;
      $display("FAIL stall_release got pc=%0d fv=%b tgt=%0d exp 20 0 20", bus.pc_in, bus.fetch_valid, bus.pc_target);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.pc_in, bus.fetch_valid} !== {9'd20, 1'b1}) begin
      errors++;
      $display("FAIL stall_resume got pc=%0d fv=%b exp 20 1", bus.pc_in, bus.fetch_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.pc_in, bus.cycle_count} !== {9'd21, c0 + 16'd5}) begin
      errors++;
      $display("FAIL stall_count got pc=%0d cnt=%0d exp pc=21 cnt=%0d", bus.pc_in, bus.cycle_count, c0 + 16'd5);
    end
    tick();
  endtask

  task automatic test_halt();
    logic [CW-1:0] c1;
    bus.halt_req = 1'b1; bus.br_req = 1'b1; bus.br_taken = 1'b1; bus.br_target = 9'd77;
    c1 = m_cnt + 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.pc_in, bus.pc_branch, bus.pc_taken, bus.fetch_valid} !== {9'd22, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL halt_drop got pc=%0d br=%b tk=%b fv=%b exp 22 0 0 1",
               bus.pc_in, bus.pc_branch, bus.pc_taken, bus.fetch_valid);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({bus.done, bus.timeout, bus.busy, bus.fetch_valid, bus.pc_in, bus.cycle_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 9'd23, c1}) begin
      errors++;
      $display("FAIL halt_done got done=%b to=%b busy=%b fv=%b pc=%0d cnt=%0d exp 1 0 0 0 23 %0d",
               bus.done, bus.timeout, bus.busy, bus.fetch_valid, bus.pc_in, bus.cycle_count, c1);
    end
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({bus.pc_in, bus.cycle_count, bus.done} !== {9'd23, c1, 1'b1}) begin
      errors++;
      $display("FAIL halt_frozen got pc=%0d cnt=%0d done=%b exp 23 %0d 1", bus.pc_in, bus.cycle_count, bus.done, c1);
    end
    bus.go = 1'b1; bus.go_addr = 9'd0;
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({bus.done, bus.timeout, bus.cycle_count, bus.pc_start, bus.pc_start_addr} !== {1'b0, 1'b0, 16'd0, 1'b1, 9'd0}) begin
      errors++;
      $display("FAIL relaunch_load got done=%b to=%b cnt=%0d start=%b addr=%0d exp 0 0 0 1 0",
               bus.done, bus.timeout, bus.cycle_count, bus.pc_start, bus.pc_start_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.pc_in, bus.fetch_valid} !== {9'd0, 1'b1}) begin
      errors++;
      $display("FAIL relaunch_run got pc=%0d fv=%b exp 0 1", bus.pc_in, bus.fetch_valid);
    end
    tick();
  endtask

  task automatic test_go_ignored();
    bus.go = 1'b1; bus.go_addr = 9'd300;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.pc_start, bus.busy, bus.fetch_valid} !== {1'b0, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL go_in_run[%0d] got start=%b busy=%b fv=%b exp 0 1 1",
                 i, bus.pc_start, bus.busy, bus.fetch_valid);
      end
      tick();
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (bus.pc_in !== 9'd5) begin
      errors++;
      $display("FAIL go_in_run_pc got pc=%0d exp 5", bus.pc_in);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    bus.halt_req = 1'b1;
    tick();
    clear_inputs();
    bus.go = 1'b1; bus.go_addr = 9'd123;
    tick();
    clear_inputs();
    tick(); tick(); tick();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.fetch_valid, bus.pc_in} !== {1'b1, 9'd125}) begin
      errors++;
      $display("FAIL midrun_before got fv=%b pc=%0d exp 1 125", bus.fetch_valid, bus.pc_in);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.pc_start, bus.pc_start_addr, bus.cycle_count, bus.busy, bus.done} !== {1'b1, 9'd0, 16'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrun_reset got start=%b addr=%0d cnt=%0d busy=%b done=%b exp 1 0 0 0 0",
               bus.pc_start, bus.pc_start_addr, bus.cycle_count, bus.busy, bus.done);
    end
    tick();
  endtask

  task automatic test_timeout();
    bus.go = 1'b1; bus.go_addr = 9'd5;
    tick();
    clear_inputs();
    tick();
    for (int i = 0; i < MAXC8; i++) begin
      @(negedge clk);
      checks++;
      if ({bus8.done, bus8.fetch_valid, bus8.cycle_count} !== {1'b0, 1'b1, 16'(i)}) begin
        errors++;
        $display("FAIL timeout_run[%0d] got done=%b fv=%b cnt=%0d exp 0 1 %0d",
                 i, bus8.done, bus8.fetch_valid, bus8.cycle_count, i);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({bus8.done, bus8.timeout, bus8.busy, bus8.cycle_count} !== {1'b1, 1'b1, 1'b0, 16'd8}) begin
      errors++;
      $display("FAIL timeout_end got done=%b to=%b busy=%b cnt=%0d exp 1 1 0 8",
               bus8.done, bus8.timeout, bus8.busy, bus8.cycle_count);
    end
    // Halt coinciding with the last budgeted cycle: halt wins
    bus.halt_req = 1'b1;
    tick();
    clear_inputs();
    bus.go = 1'b1; bus.go_addr = 9'd5;
    tick();
    clear_inputs();
    repeat (MAXC8) tick();
    bus.halt_req = 1'b1;
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({bus8.done, bus8.timeout, bus8.cycle_count} !== {1'b1, 1'b0, 16'd8}) begin
      errors++;
      $display("FAIL timeout_halt_wins got done=%b to=%b cnt=%0d exp 1 0 8",
               bus8.done, bus8.timeout, bus8.cycle_count);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      reset        = ($urandom_range(0, 63) == 0);
      bus.go       = ($urandom_range(0, 5) == 0);
      bus.go_addr  = W'($urandom_range(0, 511));
      bus.stall    = ($urandom_range(0, 3) == 0);
      bus.br_req   = ($urandom_range(0, 2) == 0);
      bus.br_taken = 1'($urandom_range(0, 1));
      bus.br_target = W'($urandom_range(0, 511));
      bus.halt_req = ($urandom_range(0, 31) == 0);
      @(negedge clk);
      checks++;
      if (dut_comb() !== predict_comb()) begin
        errors++;
        $display("FAIL rand_outputs[%0d] got %h exp %h", i, dut_comb(), predict_comb());
      end
      checks++;
      if ({bus.done, bus.timeout, bus.cycle_count} !== {m_done, m_tmo, m_cnt}) begin
        errors++;
        $display("FAIL rand_status[%0d] got done=%b to=%b cnt=%0d exp %b %b %0d",
                 i, bus.done, bus.timeout, bus.cycle_count, m_done, m_tmo, m_cnt);
      end
      tick();
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_launch();
    test_branch();
    test_stall();
    test_halt();
    test_go_ignored();
    test_reset_midrun();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
